// File: rtl/rx_protocol.sv
`default_nettype none
// ============================================================================
// Module   : rx_protocol
// Purpose  : FT245 receive-path command decoder; assembles address + data
//            frames into register-write transactions. Define RX_CHECKSUM_EN
//            to require a trailing XOR checksum byte per frame.
// Revision : 1.0
// ============================================================================
module rx_protocol #(
  parameter int DATA_BYTES     = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_rdy,
  output logic                    rx_ack,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_data,
  output logic                    reg_rdy,
  input  logic                    reg_ack,
  output logic                    frame_err,
  output logic [7:0]              err_count
);

  localparam int                 c_DATA_W   = 8 * DATA_BYTES;
  localparam int                 c_TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         c_IDX_LAST = 3'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_DATA = 2'd1,
    ST_OUT  = 2'd2
`ifdef RX_CHECKSUM_EN
    , ST_CHK = 2'd3
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [c_DATA_W-1:0]   r_reg_data;
  logic [c_DATA_W-1:0]   w_data_shift;
  logic [2:0]            r_idx;
  logic [c_TMR_W-1:0]    r_timer;
  logic                  r_frame_err;
  logic [7:0]            r_err_count;
  logic                  w_in_frame;
  logic                  w_timeout;
  logic                  w_xfer;
  logic                  w_err;
`ifdef RX_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

`ifdef RX_CHECKSUM_EN
  assign w_in_frame = (r_state == ST_DATA) || (r_state == ST_CHK);
`else
  assign w_in_frame = (r_state == ST_DATA);
`endif
  // The timeout cycle itself refuses a byte so it can start the next frame.
  assign w_timeout = w_in_frame && (r_timer == c_TMR_LAST);
  assign rx_ack    = rx_rdy && (r_state != ST_OUT) && !w_timeout;
  assign w_xfer    = rx_ack;

  assign reg_addr  = r_reg_addr;
  assign reg_data  = r_reg_data;
  assign reg_rdy   = (r_state == ST_OUT);
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

  generate
    if (DATA_BYTES == 1) begin : g_shift_single
      assign w_data_shift = rx_data;
    end else begin : g_shift_multi
      assign w_data_shift = {r_reg_data[c_DATA_W-9:0], rx_data};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      ST_ADDR: if (w_xfer) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_timeout) begin
          w_state_nxt = ST_ADDR;
          w_err       = 1'b1;
        end else if (w_xfer && (r_idx == c_IDX_LAST)) begin
`ifdef RX_CHECKSUM_EN
          w_state_nxt = ST_CHK;
`else
          w_state_nxt = ST_OUT;
`endif
        end
      end
`ifdef RX_CHECKSUM_EN
      ST_CHK: begin
        if (w_timeout) begin
          w_state_nxt = ST_ADDR;
          w_err       = 1'b1;
        end else if (w_xfer) begin
          if (rx_data == r_csum) begin
            w_state_nxt = ST_OUT;
          end else begin
            w_state_nxt = ST_ADDR;
            w_err       = 1'b1;
          end
        end
      end
`endif
      ST_OUT:  if (reg_ack) w_state_nxt = ST_ADDR;
      default: w_state_nxt = ST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ADDR;
      r_reg_addr  <= '0;
      r_reg_data  <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
`ifdef RX_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_err;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;

      if (w_in_frame && !w_xfer && !w_timeout) r_timer <= r_timer + 1'b1;
      else                                     r_timer <= '0;

      if (w_xfer) begin
        if (r_state == ST_ADDR) begin
          r_reg_addr <= rx_data[ADDR_WIDTH-1:0];
          r_idx      <= '0;
`ifdef RX_CHECKSUM_EN
          r_csum     <= rx_data;
`endif
        end else if (r_state == ST_DATA) begin
          r_reg_data <= w_data_shift;
          r_idx      <= r_idx + 3'd1;
`ifdef RX_CHECKSUM_EN
          r_csum     <= r_csum ^ rx_data;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_protocol.sv
`default_nettype none
// Scoreboard bench for rx_protocol: frame-level reference model with random
// gaps, back-pressure, timeouts and (when enabled) checksum errors.
module tb_rx_protocol;

  localparam int DB  = 2;
  localparam int AW  = 6;
  localparam int TMO = 16;
  localparam int DW  = 8 * DB;
`ifdef RX_CHECKSUM_EN
  localparam bit CS  = 1'b1;
`else
  localparam bit CS  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rdy = 1'b0;
  logic          rx_ack;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic          reg_rdy;
  logic          reg_ack;
  logic          frame_err;
  logic [7:0]    err_count;

  rx_protocol #(.DATA_BYTES(DB), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
    .reg_addr(reg_addr), .reg_data(reg_data), .reg_rdy(reg_rdy), .reg_ack(reg_ack),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_mode = 0;          // 0: hold 0, 1: hold 1, 2: random
  int exp_errs = 0;          // discarded frames since last reset
  int pulses_exp = 0;
  int pulses_seen = 0;
  logic [AW+DW-1:0] exp_q[$];

  function automatic void chk(string name, bit ok, logic [63:0] act, logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int gap(input int gmax);
    if (gmax <= 0) return 0;
    if ($urandom_range(0, 5) == 0) return $urandom_range(2, gmax);
    return $urandom_range(0, 1);
  endfunction

  task automatic idle(input int n);
    rx_rdy = 1'b0;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      got = rx_ack;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("rx_ack_wait", 1'b0, 0, 1);
    rx_rdy = 1'b0;
  endtask

  // kind 0: good, 1: stalled (timeout), 2: bad checksum. nsend limits bytes for kind 1.
  task automatic send_frame(input logic [7:0] a, input logic [DW-1:0] d,
                            input int kind, input int gmax, input int nsend);
    logic [7:0] b[$];
    logic [7:0] cs;
    int k;
    b.push_back(a);
    cs = a;
    for (int i = DB - 1; i >= 0; i--) begin
      b.push_back(d[8*i +: 8]);
      cs = cs ^ d[8*i +: 8];
    end
    if (CS) begin
      if (kind == 2) b.push_back(cs ^ 8'(1 + $urandom_range(0, 254)));
      else           b.push_back(cs);
    end
    if (kind == 1) k = (nsend > 0) ? nsend : $urandom_range(1, b.size() - 1);
    else           k = b.size();
    if (kind == 0) exp_q.push_back({a[AW-1:0], d});
    for (int i = 0; i < k; i++) begin
      if (i > 0) idle(gap(gmax));
      send_byte(b[i]);
    end
    if (kind == 1) idle(TMO + 2);
    if (kind != 0) begin
      exp_errs++;
      pulses_exp++;
    end
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain"}, exp_q.size() == 0, exp_q.size(), 0);
    idle(4);
    chk({tag, "_err_count"}, err_count == 8'((exp_errs > 255) ? 255 : exp_errs),
        err_count, (exp_errs > 255) ? 255 : exp_errs);
    chk({tag, "_pulses"}, pulses_seen == pulses_exp, pulses_seen, pulses_exp);
  endtask

  initial begin
    reg_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       reg_ack = 1'b0;
        1:       reg_ack = 1'b1;
        default: reg_ack = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: output handshakes, hold stability, back-pressure, pulse width.
  initial begin
    logic [AW+DW-1:0] e;
    logic [AW+DW-1:0] prev_out;
    bit prev_hold;
    bit prev_ferr;
    prev_hold = 1'b0;
    prev_ferr = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
        prev_ferr = 1'b0;
      end else begin
        if (reg_rdy) chk("rx_ack_in_out", rx_ack == 1'b0, rx_ack, 0);
        if (prev_hold) chk("out_hold", {reg_addr, reg_data} == prev_out, {reg_addr, reg_data}, prev_out);
        if (frame_err) begin
          pulses_seen++;
          chk("frame_err_width", !prev_ferr, 1, 0);
        end
        if (reg_rdy && reg_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1'b0, {reg_addr, reg_data}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("output", {reg_addr, reg_data} == e, {reg_addr, reg_data}, e);
          end
        end
        prev_hold = reg_rdy && !reg_ack;
        prev_out  = {reg_addr, reg_data};
        prev_ferr = frame_err;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int r;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_rdy", reg_rdy == 1'b0, reg_rdy, 0);
    chk("rst_reg_addr", reg_addr == '0, reg_addr, 0);
    chk("rst_reg_data", reg_data == '0, reg_data, 0);
    chk("rst_frame_err", frame_err == 1'b0, frame_err, 0);
    chk("rst_err_count", err_count == 8'd0, err_count, 0);
    chk("rst_rx_ack", rx_ack == 1'b0, rx_ack, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, rx_rdy held, reg_ack tied high: one-cycle reg_rdy after last byte
    ack_mode = 1;
    idle(2);
    send_frame(8'h05, 16'h1234, 0, 0, 0);
    @(negedge clk);
    chk("t1_rdy_rise", reg_rdy == 1'b1, reg_rdy, 1);
    chk("t1_addr", reg_addr == 6'h05, reg_addr, 6'h05);
    chk("t1_data", reg_data == 16'h1234, reg_data, 16'h1234);
    @(negedge clk);
    chk("t1_rdy_fall", reg_rdy == 1'b0, reg_rdy, 0);
    @(posedge clk);
    #1;
    drain_and_check("t1");

    // Back-to-back frames with reg_ack withheld
    ack_mode = 0;
    fork
      begin
        send_frame(8'h01, 16'hAABB, 0, 0, 0);
        send_frame(8'h02, 16'hCCDD, 0, 0, 0);
      end
      begin
        repeat (DB + 1 + (CS ? 1 : 0) + 10) @(posedge clk);
        @(negedge clk);
        chk("t2_held_rdy", reg_rdy == 1'b1, reg_rdy, 1);
        chk("t2_held_addr", reg_addr == 6'h01, reg_addr, 1);
        chk("t2_held_data", reg_data == 16'hAABB, reg_data, 16'hAABB);
        chk("t2_backpressure", rx_ack == 1'b0, rx_ack, 0);
        ack_mode = 1;
      end
    join
    drain_and_check("t2");

    // Reset mid-frame aborts silently
    ack_mode = 2;
    send_byte(8'h09);
    send_byte(8'h11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_errs = 0;
    @(negedge clk);
    chk("t5_reg_rdy", reg_rdy == 1'b0, reg_rdy, 0);
    chk("t5_err_count", err_count == 8'd0, err_count, 0);
    chk("t5_reg_addr", reg_addr == '0, reg_addr, 0);
    @(posedge clk);
    #1;
    send_frame(8'h0A, 16'hBEEF, 0, 0, 0);
    drain_and_check("t5");

    // Inter-byte timeout, then a clean frame
    send_frame(8'h07, 16'h5500, 1, 0, 2);
    chk("t3_err_count", err_count == 8'd1, err_count, 1);
    send_frame(8'h08, 16'h0001, 0, 0, 0);
    drain_and_check("t3");

    if (CS) begin
      send_frame(8'h03, 16'h1020, 0, 0, 0);
      send_frame(8'h03, 16'h1020, 2, 0, 0);
      drain_and_check("t6");
    end

    // Randomized frames, gaps and back-pressure
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 9);
      if (r < 2)            kind = 1;
      else if (CS && r == 2) kind = 2;
      else                  kind = 0;
      idle(gap(TMO - 2));
      send_frame(8'($urandom_range(0, 255)), DW'($urandom), kind, TMO - 2, 0);
    end
    drain_and_check("rand");

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      send_frame(8'($urandom_range(0, 255)), DW'($urandom), 1, 0, 1);
    drain_and_check("sat");
    chk("sat_value", err_count == 8'hFF, err_count, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_protocol.md
Name: rx_protocol

Overview:
- Host-to-device command decoder on the FT245 receive path.
- Consumes the byte stream delivered by the FT245 receiver over a rdy/ack stream interface.
- Assembles fixed-length frames (address byte + DATA_BYTES data bytes, MSB first) and presents each as one register-write transaction on a rdy/ack output interface to the register bank.
- Drops stalled partial frames via an inter-byte timeout and counts framing errors.

Parameters:
- DATA_BYTES, 2, data bytes per frame; reg_data width = 8*DATA_BYTES. Legal range 1..4.
- ADDR_WIDTH, 8, width of reg_addr; taken from the LSBs of the address byte. Legal range 1..8.
- TIMEOUT_CYCLES, 1000, idle clk cycles allowed between bytes inside a frame before the frame is discarded. Must be ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  received byte from FT245 receiver.
- rx_rdy  input  1  rx_data valid.
- rx_ack  output  1  byte accepted; a transfer occurs on any cycle with rx_rdy=1 and rx_ack=1.
- reg_addr  output  ADDR_WIDTH  decoded register address.
- reg_data  output  8*DATA_BYTES  decoded register data, first data byte in the MSBs.
- reg_rdy  output  1  reg_addr/reg_data valid.
- reg_ack  input  1  register bank accepts; transfer on reg_rdy=1 and reg_ack=1.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- err_count  output  8  saturating count of discarded frames.

Behaviour:
- States: ST_ADDR, ST_DATA, ST_CHK (exists only with the optional feature), ST_OUT.
- Reset (rst=1 at a clk edge):
  - State returns to ST_ADDR.
  - reg_rdy=0, reg_addr=0, reg_data=0, frame_err=0, err_count=0.
  - Byte index and timeout counters cleared.
  - Reset mid-frame or during ST_OUT aborts the transaction silently; err_count is not incremented.
- rx_ack is combinational: rx_ack = rx_rdy when state is ST_ADDR, ST_DATA or ST_CHK; rx_ack = 0 in ST_OUT. This back-pressures the receiver and does not depend on reg_ack.
- ST_ADDR:
  - On a transfer, latch reg_addr <= rx_data[ADDR_WIDTH-1:0], clear the byte index, go to ST_DATA.
  - No timeout applies in ST_ADDR.
- ST_DATA:
  - Each transfer shifts its byte into reg_data from the LSB side, so the first byte ends up in the MSBs, and increments the byte index.
  - After byte DATA_BYTES-1 (0-based), go to ST_CHK if enabled, otherwise ST_OUT.
- ST_OUT:
  - reg_rdy=1 (registered; asserted the cycle after the last byte transfer).
  - reg_addr and reg_data are held stable while reg_rdy=1.
  - On reg_ack=1, reg_rdy falls next cycle and the state returns to ST_ADDR.
  - reg_ack while reg_rdy=0 is ignored.
- Latency: last byte transfer at edge N gives reg_rdy=1 after edge N. Earliest next address byte is accepted the cycle after the reg_ack handshake.
- Timeout:
  - In ST_DATA/ST_CHK the counter increments on each cycle without a transfer and clears on each transfer.
  - When it reaches TIMEOUT_CYCLES: discard the frame, return to ST_ADDR, pulse frame_err for 1 cycle, and increment err_count.
  - err_count saturates at 255.
  - A byte arriving on the same cycle the timeout fires is not acked (rx_ack=0 that cycle); it is accepted as a new address byte afterwards.
- Frame error: frame_err is a registered pulse. reg_rdy is never asserted for a discarded frame.
- rx_rdy held continuously: one byte is consumed per clk in the accepting states; no bubble is inserted between frames except ST_OUT.

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined:
  - Each frame carries one trailing checksum byte, equal to the XOR of the address byte and all data bytes, received in ST_CHK.
  - Match: go to ST_OUT.
  - Mismatch: discard the frame, return to ST_ADDR, pulse frame_err, increment err_count.
  - The timeout applies in ST_CHK.
- Undefined: ST_CHK and its XOR accumulator are not built; frames are 1+DATA_BYTES bytes.

Test Plan:
1. Reset, then bytes 0x05,0x12,0x34 with rx_rdy held high and reg_ack tied 1 → reg_addr=0x05, reg_data=0x1234, reg_rdy high for exactly 1 cycle, starting the cycle after the 0x34 transfer; frame_err never pulses.
2. Two back-to-back frames (0x01,0xAA,0xBB then 0x02,0xCC,0xDD) with reg_ack held 0 for 10 cycles → rx_ack=0 throughout ST_OUT; first output held 0x01/0xAABB; after reg_ack, second frame yields 0x02/0xCCDD; no byte lost.
3. Bytes 0x07,0x55, then rx_rdy=0 for TIMEOUT_CYCLES (reduced to 16 for sim) → frame_err pulses once, err_count=1, no reg_rdy; next bytes 0x08,0x00,0x01 give reg_addr=0x08, reg_data=0x0001.
4. Force 300 timeouts → err_count saturates at 255.
5. Assert rst after the address byte and first data byte → state returns to ST_ADDR, reg_rdy=0, err_count unchanged; next full frame decodes correctly.
6. With RX_CHECKSUM_EN: frame 0x03,0x10,0x20,0x33 → output 0x03/0x1020; frame 0x03,0x10,0x20,0x34 → frame_err pulse, err_count increments, no reg_rdy.
